imem_arbiter: RTL

- Shares the single 64-bit memory port between the instruction-fetch path (Icache miss requests) and the data path (Dcache loads/stores).
- Issues at most one bus command per cycle.
- Records an owner for each memory tag returned at issue, then routes tagged load data back to the correct requester.
- Supports squashing in-flight fetch loads on a fetch redirect, so stale instruction lines never reach the fetch buffer.

---
 rtl/imem_arbiter.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/imem_arbiter.sv
// Arbitrates the single 64-bit memory port between Icache fetches and Dcache loads/stores,
// tracks tag ownership and routes returned load data back to its requester.
module imem_arbiter #(
    parameter int unsigned NUM_TAGS     = 15,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clock,
    input  logic        reset,

    input  logic        icache_req_valid,
    input  logic [31:0] icache_req_addr,
    output logic        icache_req_ready,
    input  logic        icache_squash,
    output logic        icache_resp_valid,
    output logic [63:0] icache_resp_data,

    input  logic        dcache_req_valid,
    input  logic        dcache_req_store,
    input  logic [31:0] dcache_req_addr,
    input  logic [63:0] dcache_req_data,
    output logic        dcache_req_ready,
    output logic        dcache_resp_valid,
    output logic [63:0] dcache_resp_data,

    output logic [1:0]  proc2mem_command,
    output logic [31:0] proc2mem_addr,
    output logic [63:0] proc2mem_data,
    input  logic [3:0]  mem2proc_response,
    input  logic [63:0] mem2proc_data,
    input  logic [3:0]  mem2proc_tag,

    output logic [3:0]  outstanding_cnt,
    output logic        spurious_tag
);

    localparam logic [1:0] BUS_NONE  = 2'd0;
    localparam logic [1:0] BUS_LOAD  = 2'd1;
    localparam logic [1:0] BUS_STORE = 2'd2;
    localparam logic [2:0] STARVE_MAX = 3'(STARVE_LIMIT);

    // Owner encoding: 0 = Icache, 1 = Dcache
    logic [NUM_TAGS:1] valid_q, valid_d;
    logic [NUM_TAGS:1] owner_q, owner_d;
    logic [NUM_TAGS:1] squashed_q, squashed_d;
    logic [NUM_TAGS:1] squashed_eff;

    logic [2:0]  starve_q, starve_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        spurious_q;
    logic        i_resp_valid_q, d_resp_valid_q;
    logic [63:0] i_resp_data_q, d_resp_data_q;

    logic grant_i, grant_d, accepted;
    logic alloc_load, alloc_owner;
    logic ret_live, ret_owner, ret_spurious;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{icache_req_addr[2:0], dcache_req_addr[2:0]};

    // Grant: Dcache has priority unless the Icache has been starved long enough
    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (!reset) begin
            if (dcache_req_valid && (!icache_req_valid || starve_q != STARVE_MAX)) begin
                grant_d = 1'b1;
            end else if (icache_req_valid) begin
                grant_i = 1'b1;
            end
        end
    end

    assign accepted         = (mem2proc_response != 4'd0);
    assign icache_req_ready = grant_i && accepted;
    assign dcache_req_ready = grant_d && accepted;

    always_comb begin
        proc2mem_command = BUS_NONE;
        proc2mem_addr    = 32'd0;
        proc2mem_data    = 64'd0;
        if (grant_d) begin
            proc2mem_command = dcache_req_store ? BUS_STORE : BUS_LOAD;
            proc2mem_addr    = {dcache_req_addr[31:3], 3'b000};
            proc2mem_data    = dcache_req_store ? dcache_req_data : 64'd0;
        end else if (grant_i) begin
            proc2mem_command = BUS_LOAD;
            proc2mem_addr    = {icache_req_addr[31:3], 3'b000};
        end
    end

    assign alloc_load  = icache_req_ready || (dcache_req_ready && !dcache_req_store);
    assign alloc_owner = dcache_req_ready;

    // Squash marks first, then the return clears, then the new allocation lands
    always_comb begin
        squashed_eff = squashed_q | (icache_squash ? (valid_q & ~owner_q) : '0);
        valid_d      = valid_q;
        owner_d      = owner_q;
        squashed_d   = squashed_eff;
        ret_live     = 1'b0;
        ret_owner    = 1'b0;
        ret_spurious = 1'b0;

        if (mem2proc_tag != 4'd0) begin
            ret_spurious = 1'b1;
            for (int t = 1; t <= int'(NUM_TAGS); t++) begin
                if (int'(mem2proc_tag) == t && valid_q[t]) begin
                    ret_spurious  = 1'b0;
                    ret_owner     = owner_q[t];
                    ret_live      = !squashed_eff[t];
                    valid_d[t]    = 1'b0;
                    squashed_d[t] = 1'b0;
                end
            end
        end

        if (alloc_load) begin
            for (int t = 1; t <= int'(NUM_TAGS); t++) begin
                if (int'(mem2proc_response) == t) begin
                    valid_d[t]    = 1'b1;
                    owner_d[t]    = alloc_owner;
                    squashed_d[t] = 1'b0;
                end
            end
        end
    end

    always_comb begin
        cnt_d = 4'd0;
        for (int t = 1; t <= int'(NUM_TAGS); t++) begin
            cnt_d = cnt_d + 4'(valid_d[t]);
        end
    end

    always_comb begin
        starve_d = starve_q;
        if (!icache_req_valid || icache_req_ready) begin
            starve_d = 3'd0;
        end else if (dcache_req_ready && starve_q < STARVE_MAX) begin
            starve_d = starve_q + 3'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q        <= '0;
            owner_q        <= '0;
            squashed_q     <= '0;
            starve_q       <= 3'd0;
            cnt_q          <= 4'd0;
            spurious_q     <= 1'b0;
            i_resp_valid_q <= 1'b0;
            d_resp_valid_q <= 1'b0;
            i_resp_data_q  <= 64'd0;
            d_resp_data_q  <= 64'd0;
        end else begin
            valid_q        <= valid_d;
            owner_q        <= owner_d;
            squashed_q     <= squashed_d;
            starve_q       <= starve_d;
            cnt_q          <= cnt_d;
            spurious_q     <= spurious_q | ret_spurious;
            i_resp_valid_q <= ret_live && !ret_owner;
            d_resp_valid_q <= ret_live && ret_owner;
            if (ret_live && !ret_owner) begin
                i_resp_data_q <= mem2proc_data;
            end
            if (ret_live && ret_owner) begin
                d_resp_data_q <= mem2proc_data;
            end
        end
    end

    assign icache_resp_valid = i_resp_valid_q;
    assign icache_resp_data  = i_resp_data_q;
    assign dcache_resp_valid = d_resp_valid_q;
    assign dcache_resp_data  = d_resp_data_q;
    assign outstanding_cnt   = cnt_q;
    assign spurious_tag      = spurious_q;

endmodule
